// File: rtl/addsub_acc_ctrl_if.sv
// Request, result and add/sub-unit signals for the accumulator controller.
// The controller connects through the slave modport; its environment through master.
interface addsub_acc_ctrl_if #(
   parameter int WIDTH = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] in_data;

   logic [WIDTH-1:0] add_a;
   logic [WIDTH-1:0] add_b;
   logic             add_cin;
   logic             add_sop;
   logic [WIDTH-1:0] add_s;
   logic             add_cout;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_acc;
   logic             out_c;
   logic             out_v;
   logic             out_z;
   logic             out_n;
   logic             busy;

   modport slave (
      input  in_valid, in_op, in_data, add_s, add_cout, out_ready,
      output in_ready, add_a, add_b, add_cin, add_sop,
             out_valid, out_acc, out_c, out_v, out_z, out_n, busy
   );

   modport master (
      output in_valid, in_op, in_data, add_s, add_cout, out_ready,
      input  in_ready, add_a, add_b, add_cin, add_sop,
             out_valid, out_acc, out_c, out_v, out_z, out_n, busy
   );
endinterface

// File: rtl/addsub_acc_ctrl.sv
// Sequencer and accumulator around a combinational ripple add/sub unit:
// accepts LOAD/ADD/SUB/CLR, holds operands for SETTLE cycles, captures S/Cout with flags.
module addsub_acc_ctrl #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input logic               clk,
   input logic               rst,
   addsub_acc_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {
      OP_LOAD = 2'b00,
      OP_ADD  = 2'b01,
      OP_SUB  = 2'b10,
      OP_CLR  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DRIVE,
      S_HOLD
   } state_e;

   localparam int             MSB      = WIDTH - 1;
   localparam int             CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(SETTLE - 1);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             c_q, c_d, v_q, v_d, z_q, z_d, n_q, n_d;
   logic             acc_we;
   logic             is_sub;
   logic             v_add, v_sub;

   // Overflow is judged against the accumulator value the unit saw as operand a.
   assign is_sub = (op_q == OP_SUB);
   assign v_add  = (acc_q[MSB] == b_q[MSB]) && (bus.add_s[MSB] != acc_q[MSB]);
   assign v_sub  = (acc_q[MSB] != b_q[MSB]) && (bus.add_s[MSB] != acc_q[MSB]);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         op_q    <= OP_LOAD;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         v_q     <= v_d;
         z_q     <= z_d;
         n_q     <= n_d;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      c_d     = c_q;
      v_d     = v_q;
      z_d     = z_q;
      n_d     = n_q;
      acc_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               op_d  = op_e'(bus.in_op);
               b_d   = bus.in_data;
               cnt_d = '0;
               case (op_e'(bus.in_op))
                  OP_LOAD: begin
                     acc_d   = bus.in_data;
                     c_d     = 1'b0;
                     v_d     = 1'b0;
                     acc_we  = 1'b1;
                     state_d = S_HOLD;
                  end
                  OP_CLR: begin
                     acc_d   = '0;
                     c_d     = 1'b0;
                     v_d     = 1'b0;
                     acc_we  = 1'b1;
                     state_d = S_HOLD;
                  end
                  default: state_d = S_DRIVE;
               endcase
            end
         end

         S_DRIVE: begin
            // The unit output is trusted only once operands have been stable for SETTLE cycles.
            if (cnt_q == CNT_LAST) begin
               acc_d   = bus.add_s;
               c_d     = bus.add_cout;
               v_d     = is_sub ? v_sub : v_add;
               acc_we  = 1'b1;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end

         S_HOLD: begin
            if (bus.out_ready) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase

      if (acc_we) begin
         z_d = (acc_d == '0);
         n_d = acc_d[MSB];
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = (state_q == S_HOLD);
   assign bus.add_a     = acc_q;
   assign bus.add_b     = b_q;
   assign bus.add_cin   = is_sub;
   assign bus.add_sop   = is_sub;
   assign bus.out_acc   = acc_q;
   assign bus.out_c     = c_q;
   assign bus.out_v     = v_q;
   assign bus.out_z     = z_q;
   assign bus.out_n     = n_q;
endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Directed bench for addsub_acc_ctrl with a behavioural 4-bit add/sub unit attached.
module tb_addsub_acc_ctrl;
   localparam int WIDTH  = 4;
   localparam int SETTLE = 2;

   logic clk = 1'b0;
   logic rst;
   logic glitch;
   logic [WIDTH:0] unit_sum;
   int   n_checks = 0;
   int   n_errors = 0;

   always #5 clk = ~clk;

   addsub_acc_ctrl_if #(.WIDTH(WIDTH)) bus ();

   addsub_acc_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Add/sub unit: a + (s_op ? ~b : b) + cin; glitch corrupts it to prove early samples are ignored.
   always_comb begin
      unit_sum = {1'b0, bus.add_a} + {1'b0, (bus.add_sop ? ~bus.add_b : bus.add_b)}
               + {{WIDTH{1'b0}}, bus.add_cin};
      if (glitch) unit_sum = ~unit_sum;
   end
   assign bus.add_s    = unit_sum[WIDTH-1:0];
   assign bus.add_cout = unit_sum[WIDTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] op, input logic [WIDTH-1:0] data);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_data  = data;
      check("in_ready before accept", 32'(bus.in_ready), 1);
      tick;
      bus.in_valid = 1'b0;
      bus.in_op    = ~op;
      bus.in_data  = ~data;
   endtask

   task automatic wait_out(input string tag, input int exp_lat);
      int cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         tick;
         cyc++;
      end
      check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
   endtask

   task automatic check_res(input string tag, input int acc, input int c, input int v,
                            input int z, input int n);
      check({tag, " out_valid"}, 32'(bus.out_valid), 1);
      check({tag, " acc"}, 32'(bus.out_acc), 32'(acc));
      check({tag, " C"}, 32'(bus.out_c), 32'(c));
      check({tag, " V"}, 32'(bus.out_v), 32'(v));
      check({tag, " Z"}, 32'(bus.out_z), 32'(z));
      check({tag, " N"}, 32'(bus.out_n), 32'(n));
   endtask

   task automatic consume(input string tag);
      tick;
      check({tag, " consumed"}, 32'(bus.out_valid), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      glitch        = 1'b0;
      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_op     = 2'b01;
      bus.in_data   = 4'd5;
      bus.out_ready = 1'b1;

      // Reset state, with a request held high throughout reset
      tick;
      check("rst out_valid", 32'(bus.out_valid), 0);
      check("rst busy", 32'(bus.busy), 0);
      check("rst acc", 32'(bus.out_acc), 0);
      check("rst C", 32'(bus.out_c), 0);
      check("rst V", 32'(bus.out_v), 0);
      check("rst Z", 32'(bus.out_z), 0);
      check("rst N", 32'(bus.out_n), 0);
      tick;
      check("no accept in rst", 32'(bus.busy), 0);
      rst = 1'b0;
      tick;
      check("accept after rst", 32'(bus.busy), 1);
      bus.in_valid = 1'b0;
      wait_out("held add5", 2);
      check_res("held add5", 5, 0, 0, 0, 0);
      consume("held add5");

      // LOAD 4; ADD 2
      req(2'b00, 4'd4);
      wait_out("load4", 0);
      check_res("load4", 4, 0, 0, 0, 0);
      consume("load4");
      req(2'b01, 4'd2);
      check("add add_a", 32'(bus.add_a), 4);
      check("add add_b", 32'(bus.add_b), 2);
      check("add cin", 32'(bus.add_cin), 0);
      check("add sop", 32'(bus.add_sop), 0);
      wait_out("4+2", 2);
      check_res("4+2", 6, 0, 0, 0, 0);
      consume("4+2");

      // LOAD 4; SUB 2
      req(2'b00, 4'd4);
      wait_out("load4b", 0);
      consume("load4b");
      req(2'b10, 4'd2);
      check("sub add_b", 32'(bus.add_b), 2);
      check("sub cin", 32'(bus.add_cin), 1);
      check("sub sop", 32'(bus.add_sop), 1);
      wait_out("4-2", 2);
      check_res("4-2", 2, 1, 0, 0, 0);
      consume("4-2");

      // LOAD 2; SUB 4
      req(2'b00, 4'd2);
      wait_out("load2", 0);
      consume("load2");
      req(2'b10, 4'd4);
      wait_out("2-4", 2);
      check_res("2-4", 14, 0, 0, 0, 1);
      consume("2-4");

      // LOAD 7; ADD 1, unit output corrupt during the first DRIVE cycle
      req(2'b00, 4'd7);
      wait_out("load7", 0);
      consume("load7");
      req(2'b01, 4'd1);
      glitch = 1'b1;
      tick;
      check("7+1 mid-drive", 32'(bus.out_valid), 0);
      glitch = 1'b0;
      wait_out("7+1", 1);
      check_res("7+1", 8, 0, 1, 0, 1);
      consume("7+1");

      // LOAD 15; ADD 1
      req(2'b00, 4'd15);
      wait_out("load15", 0);
      consume("load15");
      req(2'b01, 4'd1);
      wait_out("15+1", 2);
      check_res("15+1", 0, 1, 0, 1, 0);
      consume("15+1");

      // ADD 3 with downstream stalled for 5 cycles and a competing request
      bus.out_ready = 1'b0;
      req(2'b01, 4'd3);
      wait_out("stall", 2);
      bus.in_valid = 1'b1;
      bus.in_op    = 2'b00;
      bus.in_data  = 4'd9;
      for (int i = 0; i < 5; i++) begin
         check_res("stall", 3, 0, 0, 0, 0);
         check("stall in_ready", 32'(bus.in_ready), 0);
         tick;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      consume("stall");
      check("stall idle in_ready", 32'(bus.in_ready), 1);
      check("stall acc kept", 32'(bus.out_acc), 3);

      // Reset mid-DRIVE, then CLR
      req(2'b00, 4'd4);
      wait_out("load4c", 0);
      consume("load4c");
      req(2'b01, 4'd2);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("drive rst busy", 32'(bus.busy), 0);
      check("drive rst out_valid", 32'(bus.out_valid), 0);
      check("drive rst acc", 32'(bus.out_acc), 0);
      check("drive rst in_ready", 32'(bus.in_ready), 1);
      tick;
      check("drive rst stays idle", 32'(bus.out_valid), 0);
      req(2'b11, 4'd9);
      wait_out("clr", 0);
      check_res("clr", 0, 0, 0, 1, 0);
      consume("clr");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
